// File: rtl/tube_scan_driver.sv
// Time-multiplexed seven-segment scan driver with shadowed digit/mask registers.
// Optional blink feature enabled by defining TUBE_BLINK_EN.
module tube_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   tubsel
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0]           r_pre;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_dig;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;

    logic                    w_tick;
    logic                    w_blink;
    logic [3:0]              w_nib;
    logic [7:0]              w_hex;
    logic [7:0]              w_pat;
    logic [NUM_DIGITS-1:0]   w_onehot;

    assign w_tick = (r_pre == PMAX);
    assign w_nib  = r_dig[{r_idx, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (!enable) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IMAX) ? '0 : r_idx + 1'b1;
            end
        end
    end

`ifdef TUBE_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BMAX = BW'(BLINK_TICKS - 1);

    logic [NUM_DIGITS-1:0] r_blink;
    logic [BW-1:0]         r_bcnt;
    logic                  r_phase;

    // Phase flips once per BLINK_TICKS scan ticks; idle clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (!enable) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_bcnt == BMAX) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= '0;
        end else if (load) begin
            r_blink <= blink_mask;
        end
    end

    assign w_blink = r_phase & r_blink[r_idx];
`else
    logic w_unused_blink;
    assign w_unused_blink = ^blink_mask;
    assign w_blink        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig   <= '0;
            r_dp    <= '0;
            r_blank <= '0;
        end else if (load) begin
            r_dig   <= digits;
            r_dp    <= dp_mask;
            r_blank <= blank_mask;
        end
    end

    always_comb begin
        w_hex = 8'h00;
        case (w_nib)
            4'h0: w_hex = 8'hFC;
            4'h1: w_hex = 8'h60;
            4'h2: w_hex = 8'hDA;
            4'h3: w_hex = 8'hF2;
            4'h4: w_hex = 8'h66;
            4'h5: w_hex = 8'hB6;
            4'h6: w_hex = 8'hBE;
            4'h7: w_hex = 8'hE0;
            4'h8: w_hex = 8'hFE;
            4'h9: w_hex = 8'hF6;
            4'hA: w_hex = 8'hEE;
            4'hB: w_hex = 8'h3E;
            4'hC: w_hex = 8'h9C;
            4'hD: w_hex = 8'h7A;
            4'hE: w_hex = 8'h9E;
            4'hF: w_hex = 8'h8E;
            default: w_hex = 8'h00;
        endcase
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

    assign w_pat = (r_blank[r_idx] | w_blink) ? 8'h00
                 : {w_hex[7:1], r_dp[r_idx]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg    <= 8'h00;
            tubsel <= '0;
        end else if (!enable) begin
            seg    <= 8'h00;
            tubsel <= '0;
        end else begin
            seg    <= w_pat;
            tubsel <= w_onehot;
        end
    end

endmodule

// File: tb/tb_tube_scan_driver.sv
// Scoreboard bench for tube_scan_driver (NUM_DIGITS=4, SCAN_DIV=4, BLINK_TICKS=2).
module tb_tube_scan_driver;

    localparam int ND = 4;
    localparam int DV = 4;
    localparam int BT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits = '0;
    logic [3:0]    dp_mask = '0;
    logic [3:0]    blank_mask = '0;
    logic [3:0]    blink_mask = '0;
    logic [7:0]    seg;
    logic [3:0]    tubsel;

    int total = 0;
    int bad = 0;

    logic [11:0] q[$];
    logic [11:0] exp_v;

    int          m_pre, m_idx, m_bcnt;
    logic        m_phase;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_blank, m_blink;

    tube_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(DV), .BLINK_TICKS(BT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .digits(digits), .dp_mask(dp_mask), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .seg(seg), .tubsel(tubsel)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hexseg(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        return t[n];
    endfunction

    function automatic logic [11:0] model_out();
        logic [7:0] s;
        logic       off;
        off = m_blank[m_idx];
`ifdef TUBE_BLINK_EN
        off = off | (m_phase & m_blink[m_idx]);
`endif
        s = off ? 8'h00 : (hexseg(m_dig[m_idx*4 +: 4]) | {7'b0, m_dp[m_idx]});
        return {s, 4'(1 << m_idx)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pre <= 0; m_idx <= 0; m_bcnt <= 0; m_phase <= 1'b0;
            m_dig <= '0; m_dp <= '0; m_blank <= '0; m_blink <= '0;
            q.delete();
        end else begin
            q.push_back(enable ? model_out() : 12'h000);
            if (enable) begin
                if (m_pre == DV - 1) begin
                    m_pre <= 0;
                    m_idx <= (m_idx + 1) % ND;
                    if (m_bcnt == BT - 1) begin
                        m_bcnt  <= 0;
                        m_phase <= ~m_phase;
                    end else begin
                        m_bcnt <= m_bcnt + 1;
                    end
                end else begin
                    m_pre <= m_pre + 1;
                end
            end else begin
                m_pre <= 0; m_idx <= 0; m_bcnt <= 0; m_phase <= 1'b0;
            end
            if (load) begin
                m_dig <= digits; m_dp <= dp_mask;
                m_blank <= blank_mask; m_blink <= blink_mask;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({seg, tubsel} !== 12'h000) begin
            bad++;
            $display("FAIL reset_hold: got %h/%b want 00/0000", seg, tubsel);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({seg, tubsel} !== 12'h000) begin
                bad++;
                $display("FAIL reset_idle: got %h/%b want 00/0000", seg, tubsel);
            end
        end
    endtask

    task automatic test_scan();
        logic [7:0] segs [4];
        logic [3:0] et;
        int tb;
        segs = '{8'hFC, 8'h60, 8'hDA, 8'hF2};
        digits = 16'h3210;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 2 * ND * DV; c++) begin
            @(negedge clk);
            tb = (c / DV) % ND;
            et = 4'b0001 << tb;
            total++;
            if (seg !== segs[tb] || tubsel !== et) begin
                bad++;
                $display("FAIL scan_c%0d: got %h/%b want %h/%b", c, seg, tubsel, segs[tb], et);
            end
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scan_sb: no expected entry");
            end else begin
                exp_v = q[$];
                q.delete();
                if ({seg, tubsel} !== exp_v) begin
                    bad++;
                    $display("FAIL scan_sb: got %h want %h", {seg, tubsel}, exp_v);
                end
            end
        end
    endtask

    task automatic test_masks();
        int hit1, hit3;
        hit1 = 0; hit3 = 0;
        dp_mask = 4'b0010;
        blank_mask = 4'b1000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 2 * ND * DV; c++) begin
            @(negedge clk);
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL masks_sb: no expected entry");
            end else begin
                exp_v = q[$];
                q.delete();
                if (exp_v == {8'h61, 4'b0010}) hit1++;
                if (exp_v == {8'h00, 4'b1000}) hit3++;
                if ({seg, tubsel} !== exp_v) begin
                    bad++;
                    $display("FAIL masks_sb: got %h want %h", {seg, tubsel}, exp_v);
                end
            end
        end
        total++;
        if (hit1 != 2 * DV || hit3 != 2 * DV) begin
            bad++;
            $display("FAIL masks_cover: tube1=61 %0d tube3=00 %0d want %0d", hit1, hit3, 2 * DV);
        end
    endtask

    task automatic test_load_timing();
        int k;
        digits = 16'hFFFF;
        for (int c = 0; c < ND * DV; c++) begin
            @(negedge clk);
            total++;
            exp_v = q[$];
            q.delete();
            if ({seg, tubsel} !== exp_v) begin
                bad++;
                $display("FAIL noload_sb: got %h want %h", {seg, tubsel}, exp_v);
            end
        end
        digits = 16'h321F;
        k = 0;
        while (!(m_idx == 0 && m_pre == 1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k >= 100) begin
            bad++;
            $display("FAIL load_wait: tube0 slot not reached got %0d want <100", k);
        end
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        total++;
        if ({seg, tubsel} !== {8'hFC, 4'b0001}) begin
            bad++;
            $display("FAIL load_edge1: got %h/%b want FC/0001", seg, tubsel);
        end
        @(negedge clk);
        total++;
        if ({seg, tubsel} !== {8'h8E, 4'b0001}) begin
            bad++;
            $display("FAIL load_edge2: got %h/%b want 8E/0001", seg, tubsel);
        end
        q.delete();
    endtask

    task automatic test_enable_drop();
        int k;
        k = 0;
        while (m_idx != 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        q.delete();
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({seg, tubsel} !== 12'h000) begin
            bad++;
            $display("FAIL drop: got %h/%b want 00/0000", seg, tubsel);
        end
        @(negedge clk);
        @(negedge clk);
        enable = 1'b1;
        for (int c = 0; c < DV + 1; c++) begin
            @(negedge clk);
            total++;
            if (tubsel !== ((c < DV) ? 4'b0001 : 4'b0010)) begin
                bad++;
                $display("FAIL reenable_c%0d: got %b want %b", c, tubsel,
                         (c < DV) ? 4'b0001 : 4'b0010);
            end
            total++;
            exp_v = q[$];
            q.delete();
            if ({seg, tubsel} !== exp_v) begin
                bad++;
                $display("FAIL reenable_sb: got %h want %h", {seg, tubsel}, exp_v);
            end
        end
    endtask

    task automatic test_blink();
        digits = 16'h3210;
        dp_mask = 4'b0000;
        blank_mask = 4'b0000;
        blink_mask = 4'b0001;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 4 * ND * DV; c++) begin
            @(negedge clk);
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL blink_sb: no expected entry");
            end else begin
                exp_v = q[$];
                q.delete();
                if ({seg, tubsel} !== exp_v) begin
                    bad++;
                    $display("FAIL blink_sb: got %h want %h", {seg, tubsel}, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_midscan();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({seg, tubsel} !== 12'h000) begin
            bad++;
            $display("FAIL rst_mid: got %h/%b want 00/0000", seg, tubsel);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < ND * DV; c++) begin
            @(negedge clk);
            total++;
            if (seg !== 8'hFC) begin
                bad++;
                $display("FAIL rst_shadow_c%0d: got %h want FC", c, seg);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_masks();
        test_load_timing();
        test_enable_drop();
        test_blink();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
